// File: rtl/gp_pkg.sv
// Shared pipeline types for the fetch/decode boundary.
package gp_pkg;

  localparam int GP_XLEN = 32;
  localparam int GP_ILEN = 32;

  // Bubble instruction presented to decode when nothing is queued (add x0,x0,x0).
  localparam logic [GP_ILEN-1:0] NOP_INSTR = 32'h0000_0033;

  typedef struct packed {
    logic [GP_XLEN-1:0] pc;
    logic [GP_ILEN-1:0] instr;
    logic               misaligned;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_decode_queue.sv
// Instruction buffer between fetch and decode: a DEPTH-entry FIFO with
// valid/ready on both sides, flush discard and exception-pending push gating.
// When empty, decode sees a NOP bubble carrying the last consumed PC.
module fetch_decode_queue
  import gp_pkg::*;
#(
  parameter int               XLEN  = 32,
  parameter int               ILEN  = 32,
  parameter int               DEPTH = 4,
  parameter logic [ILEN-1:0]  NOP   = NOP_INSTR
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [XLEN-1:0]            in_pc,
  input  logic [ILEN-1:0]            in_instr,
  input  logic                       in_misaligned,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            out_pc,
  output logic [ILEN-1:0]            out_instr,
  output logic                       out_misaligned,
  input  logic                       flush,
  input  logic                       exception_pending,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_pkt_t        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [XLEN-1:0]   r_lastPc;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  fetch_pkt_t        w_inPkt;
  fetch_pkt_t        w_headPkt;

  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A full queue can still accept when the head leaves in the same cycle.
  assign in_ready = !flush && !exception_pending && (!w_full || out_ready);

  assign w_push = in_valid && in_ready;
  assign w_pop  = !w_empty && out_ready;

  assign w_inPkt.pc         = in_pc;
  assign w_inPkt.instr      = in_instr;
  assign w_inPkt.misaligned = in_misaligned;

  assign w_headPkt = r_mem[r_head];

  // Entry storage: written at the tail on every accepted push, never reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_tail] <= w_inPkt;
    end
  end

  // Pointer, occupancy and last-PC bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_lastPc <= '0;
    end else if (flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head   <= r_head + PTR_W'(1);
        r_lastPc <= w_headPkt.pc;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  // Decode-side view: head entry when occupied, otherwise a NOP bubble.
  always_comb begin
    out_valid      = 1'b0;
    out_pc         = r_lastPc;
    out_instr      = NOP;
    out_misaligned = 1'b0;
    if (!w_empty) begin
      out_valid      = 1'b1;
      out_pc         = w_headPkt.pc;
      out_instr      = w_headPkt.instr;
      out_misaligned = w_headPkt.misaligned;
    end
  end

  assign count = r_count;
  assign full  = w_full;
  assign empty = w_empty;

  // Structural sanity: power-of-two depth so pointers wrap naturally.
  assert property (@(posedge clk) (DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0));

  // Packet layout is fixed by the shared package.
  assert property (@(posedge clk) (XLEN == GP_XLEN) && (ILEN == GP_ILEN));

  // No entry is ever written while the queue is refusing input.
  assert property (@(posedge clk) disable iff (rst) !(w_push && !in_ready));

  // Occupancy never exceeds capacity.
  assert property (@(posedge clk) disable iff (rst) r_count <= CNT_W'(DEPTH));

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Parametrised instruction buffer between the frontend (fetch) stage and the decode stage. It replaces the single fetch-to-decode pipe register with a DEPTH-entry FIFO and valid/ready handshakes on both sides. Each entry carries PC, instruction word and the instruction-address-misaligned flag. When it has no valid entry, the decode side sees a NOP bubble. Flush and exception-pending handling follow the pipeline's discard/commit semantics.

## Interface
Parameters:
- XLEN, 32, PC width
- ILEN, 32, instruction width
- DEPTH, 4, entry count; power of two, ≥ 2
- NOP, 32'h0000_0033, bubble instruction (add x0,x0,x0)

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  frontend offers an entry
- in_ready  output  1  queue accepts an entry this cycle
- in_pc  input  XLEN  PC of offered instruction
- in_instr  input  ILEN  offered instruction word
- in_misaligned  input  1  instruction-address-misaligned flag from frontend
- out_valid  output  1  head entry valid
- out_ready  input  1  decode consumes head this cycle (deasserted by scoreboard/memory stall)
- out_pc  output  XLEN  head PC, or last-consumed PC when empty
- out_instr  output  ILEN  head instruction, or NOP when empty
- out_misaligned  output  1  head flag, 0 when empty
- flush  input  1  discard all entries (branch/jump redirect, discardwire)
- exception_pending  input  1  from commit; blocks new pushes
- count  output  $clog2(DEPTH+1)  occupancy
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- Storage: DEPTH × {pc, instr, misaligned} registers; head and tail pointers of $clog2(DEPTH) bits, wrapping naturally modulo DEPTH; count register.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = !flush & !exception_pending & (!full | out_ready). A push into a full queue is allowed only with a simultaneous pop.
- out_valid = !empty. Outputs are driven combinationally from the head entry; there is no input→output bypass.
- Push writes at tail, then tail+1. Pop advances head and loads last_pc ← head pc.
- Push and pop in the same cycle: count is unchanged, both pointers advance.
- Flush has highest priority. Next cycle: head = tail = count = 0. Any same-cycle push or pop is ignored, and last_pc is unchanged.
- exception_pending only gates in_ready. Pops continue so that older instructions drain.
- Empty output: out_instr = NOP, out_pc = last_pc, out_misaligned = 0, out_valid = 0.

## Timing
- Reset values:
  - head = tail = count = 0, last_pc = 0
  - in_ready = 1 (if flush and exception_pending are low)
  - out_valid = 0, out_instr = NOP, out_pc = 0, out_misaligned = 0
  - full = 0, empty = 1
- Latency: an entry pushed in cycle n is visible at the output in cycle n+1 at the earliest.
- Throughput: one push and one pop per cycle sustained at any occupancy, including full.
- Reset mid-operation behaves as flush, and additionally clears last_pc. Storage contents are don't-care after reset.
- in_ready is not registered. It depends combinationally on flush, exception_pending and out_ready.

## Structure
- Shared package gp_pkg:
  - fetch_pkt_t packed struct {pc, instr, misaligned}
  - constant NOP_INSTR = 32'h0000_0033, used as the NOP default
- Single module. Storage is an unpacked array of fetch_pkt_t; no sub-module.
- Assertions:
  - DEPTH is a power of two
  - no push while !in_ready
  - count ≤ DEPTH

## Test plan
- Reset, then idle → out_valid=0, out_instr=32'h33, out_pc=0, empty=1, in_ready=1.
- Fill and drain: push PCs 0x100, 0x104, 0x108, 0x10C with out_ready=0 → full=1 and in_ready=0 after the 4th push. Then out_ready=1 → pops in order over 4 cycles, after which out_pc=0x10C and out_instr=NOP.
- Simultaneous push/pop while full, 8 cycles of continuous traffic → count stays 4, output order matches input order, wrap-around is exercised.
- Flush with 3 entries and a same-cycle push of 0x200 → next cycle count=0, out_valid=0; 0x200 is never output.
- exception_pending=1 with 2 entries and in_valid=1 → in_ready=0, both entries drain, count=0. Deassert → pushes resume.
- in_misaligned=1 on the 2nd push → out_misaligned=1 only while that entry is at the head.
